// File: rtl/pipeline_stage_reg.sv
// -----------------------------------------------------------------------------
// pipeline_stage_reg
//
// Purpose:
//   Valid/ready pipeline register between two processor pipeline stages. It
//   carries a datapath payload (PC, operands, immediate) and a control payload
//   (ALU op, selects, mem/reg enables). It supports a global STALL freeze and a
//   FLUSH that discards every held entry.
//
//   SKID = 1 : two-entry skid buffer (main register plus skid register).
//              IN_READY comes from a register, so there is no combinational
//              path from OUT_READY to IN_READY.
//   SKID = 0 : single register. IN_READY passes OUT_READY through
//              combinationally. At most one entry is held.
//
// Parameters:
//   DATA_W  width of the datapath payload
//   CTRL_W  width of the control payload
//   SKID    1 = skid buffer, 0 = single register with ready pass-through
//
// Ports:
//   CLK        in   clock; all state changes on its rising edge
//   RESET      in   synchronous, active-high reset
//   IN_VALID   in   upstream presents a valid entry
//   IN_READY   out  stage accepts an entry this cycle
//   IN_DATA    in   upstream datapath payload
//   IN_CTRL    in   upstream control payload
//   STALL      in   global freeze; no transfer on either side
//   FLUSH      in   discard all held entries
//   OUT_VALID  out  head entry valid
//   OUT_READY  in   downstream accepts the head entry
//   OUT_DATA   out  head datapath payload
//   OUT_CTRL   out  head control payload; zero when OUT_VALID = 0
//   OCCUPANCY  out  number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipeline_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 24,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [CTRL_W-1:0] IN_CTRL,
    input  logic              STALL,
    input  logic              FLUSH,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [1:0]        OCCUPANCY
);

    // The state encoding is also the entry count, so it drives OCCUPANCY directly.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                in_ready_q;
    logic [DATA_W-1:0]   data_q;
    logic [CTRL_W-1:0]   ctrl_q;
    logic [DATA_W-1:0]   skid_data_q;
    logic [CTRL_W-1:0]   skid_ctrl_q;

    logic                out_valid;
    logic                accept;
    logic                pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = IN_VALID && IN_READY;
    assign pop       = out_valid && OUT_READY && !STALL;

    // STALL and RESET gate IN_READY combinationally in both modes. RESET is
    // included so that the stage never advertises readiness while held in reset.
    generate
        if (SKID != 0) begin : g_skid
            assign IN_READY = in_ready_q && !STALL && !RESET;
        end else begin : g_noskid
            assign IN_READY = (!out_valid || OUT_READY) && !STALL && !RESET;
        end
    endgenerate

    // Next state. FLUSH and RESET override this in the register block.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) state_d = ST_ONE;
            end
            ST_ONE: begin
                // Without a skid register, accepting in ONE implies a pop.
                if (accept && !pop && (SKID != 0)) state_d = ST_TWO;
                else if (pop && !accept)           state_d = ST_EMPTY;
            end
            ST_TWO: begin
                if (pop) state_d = ST_ONE;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            data_q      <= '0;
            ctrl_q      <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (FLUSH) begin
            // Payload registers keep their old contents. OUT_CTRL is masked while empty.
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        data_q <= IN_DATA;
                        ctrl_q <= IN_CTRL;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        data_q <= IN_DATA;
                        ctrl_q <= IN_CTRL;
                    end else if (accept) begin
                        skid_data_q <= IN_DATA;
                        skid_ctrl_q <= IN_CTRL;
                    end
                end
                ST_TWO: begin
                    // The main register drains, so the skid entry becomes the head.
                    if (pop) begin
                        data_q <= skid_data_q;
                        ctrl_q <= skid_ctrl_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign OUT_VALID = out_valid;
    assign OUT_DATA  = data_q;
    assign OUT_CTRL  = out_valid ? ctrl_q : '0;
    assign OCCUPANCY = state_q;

endmodule

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 Parameter DATA_W, default 96, SHALL set the width of the datapath payload (PC, operands, immediate).
REQ-002 Parameter CTRL_W, default 24, SHALL set the width of the control payload (ALU op, selects, mem/reg enables).
REQ-003 Parameter SKID, default 1, SHALL select the mode: 1 = two-entry skid buffer; 0 = single register with combinational ready pass-through.
REQ-004 CLK  input  1  clock; all state changes on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 IN_VALID  input  1  upstream stage presents a valid entry.
REQ-007 IN_READY  output  1  stage accepts an entry this cycle.
REQ-008 IN_DATA  input  DATA_W  upstream datapath payload.
REQ-009 IN_CTRL  input  CTRL_W  upstream control payload.
REQ-010 STALL  input  1  global freeze (memory busy-wait); no transfer on either side.
REQ-011 FLUSH  input  1  discard all held entries (branch mispredict or exception).
REQ-012 OUT_VALID  output  1  head entry valid.
REQ-013 OUT_READY  input  1  downstream stage accepts the head entry.
REQ-014 OUT_DATA  output  DATA_W  head datapath payload.
REQ-015 OUT_CTRL  output  CTRL_W  head control payload; all zeros whenever OUT_VALID=0 (bubble).
REQ-016 OCCUPANCY  output  2  number of held entries, 0 to 2.

Function
REQ-017 Accept SHALL occur when IN_VALID && IN_READY; pop SHALL occur when OUT_VALID && OUT_READY && !STALL.
REQ-018 SKID=1: the FSM SHALL have states EMPTY (0 entries), ONE (1 entry in the main register) and TWO (main register plus skid register).
REQ-019 SKID=1 transitions: EMPTY--accept-->ONE; ONE--accept, no pop-->TWO; ONE--pop, no accept-->EMPTY; ONE--accept and pop-->ONE (new entry into the main register); TWO--pop-->ONE (skid entry moves to the main register); in all other cases the state is held.
REQ-020 SKID=1: IN_READY SHALL be registered, equal to (next state != TWO) && !STALL, with no combinational path from OUT_READY.
REQ-021 SKID=0: IN_READY SHALL be (!OUT_VALID || OUT_READY) && !STALL; OCCUPANCY SHALL never exceed 1; state TWO is unreachable.
REQ-022 Latency SHALL be 1 cycle: an entry accepted at edge N appears on OUT_* after edge N when the stage was empty.
REQ-023 Ordering SHALL be strict FIFO; no entry is dropped or duplicated unless FLUSH is asserted.
REQ-024 While OUT_VALID=1 and no pop occurs, OUT_DATA and OUT_CTRL SHALL remain stable.
REQ-025 STALL=1 SHALL freeze all state, outputs and OCCUPANCY, and SHALL force IN_READY=0 combinationally.
REQ-026 FLUSH=1 at an edge SHALL give state EMPTY, OUT_VALID=0, OUT_CTRL=0 and OCCUPANCY=0; any entry presented in the same cycle is discarded.
REQ-027 FLUSH SHALL take priority over STALL and over accept/pop; RESET SHALL take priority over FLUSH.
REQ-028 OUT_DATA after a flush is don't-care but SHALL not be X in simulation; it holds its prior value.

Reset
REQ-029 RESET=1 at an edge SHALL give state EMPTY, OUT_VALID=0, OUT_DATA=0, OUT_CTRL=0, OCCUPANCY=0 and IN_READY=0 during reset.
REQ-030 IN_READY SHALL become 1 on the first cycle after RESET deasserts, provided STALL=0.
REQ-031 RESET asserted mid-operation, including in state TWO, SHALL discard all entries, with no pop reported on the following cycle.

Verification
REQ-032 Reset release with SKID=1: drive IN_VALID=1 with DATA=0x11 and OUT_READY=1 -> OUT_VALID=1 and OUT_DATA=0x11 one cycle after the accept; OCCUPANCY=1.
REQ-033 Backpressure: hold OUT_READY=0 and send 0x11 then 0x22 -> OCCUPANCY=2 and IN_READY=0; then raise OUT_READY -> 0x11 and 0x22 delivered in order, IN_READY returns to 1.
REQ-034 STALL: assert STALL for 3 cycles while in state ONE with OUT_READY=1 -> OUT_* unchanged, IN_READY=0, no pop; after release the pop occurs on the next edge.
REQ-035 FLUSH in state TWO together with IN_VALID=1 (DATA=0x33) -> next cycle OUT_VALID=0, OUT_CTRL=0, OCCUPANCY=0; 0x33 never appears on OUT_*.
REQ-036 SKID=0 streaming of 0x01..0x08 with OUT_READY toggling every cycle -> all 8 values delivered in order, OCCUPANCY<=1 throughout, full throughput while OUT_READY=1.
REQ-037 Simultaneous RESET and FLUSH with STALL=1 in state TWO -> reset values per REQ-029 on the next cycle.
